// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end. Owns the fetch PC, issues in-order requests
//   to instruction memory, tags each request with its PC, and buffers the
//   returned words in a small in-order queue that feeds decode through a
//   valid/ready handshake. A taken branch from decode flushes the queue and
//   discards every response still in flight.
//
// Parameters
//   DEPTH     queue entries; also caps queue occupancy + outstanding requests
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, reset                    clock, asynchronous active-low reset
//   imem_req/addr/gnt             request channel (accepted on req & gnt)
//   imem_rvalid/rdata             in-order response channel
//   br_taken, uncond_br,
//   cond_addr19, br_addr26, br_pc redirect from decode
//   if_valid/ready/instruction/pc head of the queue towards decode
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic        uncond_br,
    input  logic [18:0] cond_addr19,
    input  logic [25:0] br_addr26,
    input  logic [63:0] br_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [63:0] if_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;   // counts span 0..DEPTH

    logic [63:0]   fpc;
    logic [31:0]   q_instr [DEPTH];
    logic [63:0]   q_pc    [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ, infl, drop;

    // PCs of outstanding requests; its occupancy always equals infl.
    logic [63:0]   tag_mem [DEPTH];
    logic [AW-1:0] tag_wr, tag_rd;

    logic          grant, push, pop;
    logic [CW:0]   committed;
    logic [63:0]   br_offset, br_target;
    logic [CW-1:0] occ_nxt, infl_nxt;

    // Slots already promised: entries held plus responses still to come.
    // Only registered counts are used, so a response can never find the queue full.
    assign committed = {1'b0, occ} + {1'b0, infl};

    // Gated by reset so the request line is quiet while reset is held.
    assign imem_req  = reset && !br_taken && (committed < (CW+1)'(DEPTH));
    assign imem_addr = fpc;
    assign grant     = imem_req && imem_gnt;

    assign if_valid       = (occ != '0) && !br_taken;
    assign if_instruction = q_instr[rd_ptr];
    assign if_pc          = q_pc[rd_ptr];
    assign pop            = if_valid && if_ready;

    // Responses owed to a flushed path are swallowed until drop reaches zero.
    assign push = imem_rvalid && (drop == '0) && !br_taken;

    // Word offsets are sign-extended and scaled to bytes; the add wraps mod 2^64.
    assign br_offset = uncond_br ? {{36{br_addr26[25]}}, br_addr26, 2'b00}
                                 : {{43{cond_addr19[18]}}, cond_addr19, 2'b00};
    assign br_target = br_pc + br_offset;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        occ_nxt = occ;
        if (push && !pop)
            occ_nxt = occ + CW'(1);
        else if (!push && pop)
            occ_nxt = occ - CW'(1);
    end

    always_comb begin
        infl_nxt = infl;
        if (grant && !imem_rvalid)
            infl_nxt = infl + CW'(1);
        else if (!grant && imem_rvalid)
            infl_nxt = infl - CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc    <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            infl   <= '0;
            drop   <= '0;
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            infl <= infl_nxt;
            // Tags drain with responses even across a redirect.
            if (imem_rvalid)
                tag_rd <= tag_rd + AW'(1);
            if (grant)
                tag_wr <= tag_wr + AW'(1);

            if (br_taken) begin
                fpc    <= br_target;
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                // A response landing in the redirect cycle is already discarded.
                drop   <= infl - CW'(imem_rvalid);
            end else begin
                if (grant)
                    fpc <= fpc + 64'd4;
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (imem_rvalid && (drop != '0))
                    drop <= drop - CW'(1);
                occ <= occ_nxt;
            end
        end
    end

    // NOTE: the queue storage is reset because the head is visible on if_instruction/if_pc,
    // which must read zero in reset; the tag storage below is never observed before written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= tag_mem[tag_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (grant)
            tag_mem[tag_wr] <= fpc;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a randomised-latency in-order instruction memory
// drives the DUT, and a queue-based reference model predicts the request,
// handshake and head-of-queue outputs each cycle. Delivered instructions are
// also checked against program order and memory contents.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic        uncond_br;
    logic [18:0] cond_addr19;
    logic [25:0] br_addr26;
    logic [63:0] br_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .br_taken       (br_taken),
        .uncond_br      (uncond_br),
        .cond_addr19    (cond_addr19),
        .br_addr26      (br_addr26),
        .br_pc          (br_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc)
    );

    int checks = 0;
    int errors = 0;

    // Memory: addresses granted but not yet answered, and per-cycle odds.
    logic [63:0] pend[$];
    int          gnt_pct;
    int          rv_pct;

    // Reference model.
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;
    entry_t      mq[$];      // buffered entries, head first
    logic [63:0] m_tags[$];  // PCs of requests in flight
    logic [63:0] m_fpc;
    int          m_drop;
    logic [63:0] next_pc;    // program-order PC of the next delivery
    logic [63:0] popped[$];  // PCs handed to decode

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] redirect_target(input logic [63:0] pc, input logic uncond,
                                                    input logic [18:0] c19, input logic [25:0] b26);
        longint off;
        off = uncond ? longint'($signed(b26)) : longint'($signed(c19));
        return pc + 64'(off * 4);
    endfunction

    // Asserts reset for one cycle starting now, checks the reset values
    // immediately, and restarts memory and model.
    task automatic apply_reset();
        reset = 1'b0;
        br_taken = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_imem_addr: got %h expected %h", imem_addr, RESET_PC); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
        checks++; if (if_instruction !== 32'h0) begin errors++; $display("FAIL rst_if_instruction: got %h expected 0", if_instruction); end
        checks++; if (if_pc !== 64'h0) begin errors++; $display("FAIL rst_if_pc: got %h expected 0", if_pc); end
        pend.delete();
        mq.delete();
        m_tags.delete();
        popped.delete();
        m_fpc = RESET_PC;
        next_pc = RESET_PC;
        m_drop = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock cycle. Caller sets br_* and if_ready at the falling edge;
    // the memory decides gnt/rvalid here; outputs are checked before the rising edge.
    task automatic cycle();
        logic        exp_req, exp_valid, grant, pop;
        logic [63:0] t;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (pend.size() != 0 && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        exp_req   = !br_taken && (mq.size() + m_tags.size() < DEPTH);
        exp_valid = (mq.size() != 0) && !br_taken;
        checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL imem_req @%0t: got %b expected %b", $time, imem_req, exp_req); end
        checks++; if (imem_addr !== m_fpc) begin errors++; $display("FAIL imem_addr @%0t: got %h expected %h", $time, imem_addr, m_fpc); end
        checks++; if (if_valid !== exp_valid) begin errors++; $display("FAIL if_valid @%0t: got %b expected %b", $time, if_valid, exp_valid); end
        if (exp_valid) begin
            checks++; if (if_pc !== mq[0].pc) begin errors++; $display("FAIL if_pc @%0t: got %h expected %h", $time, if_pc, mq[0].pc); end
            checks++; if (if_instruction !== mq[0].instr) begin errors++; $display("FAIL if_instruction @%0t: got %h expected %h", $time, if_instruction, mq[0].instr); end
        end

        grant = exp_req && imem_gnt;
        pop   = exp_valid && if_ready;
        if (pop) begin
            checks++; if (if_pc !== next_pc) begin errors++; $display("FAIL order @%0t: got pc %h expected %h", $time, if_pc, next_pc); end
            checks++; if (if_instruction !== mem_word(next_pc)) begin errors++; $display("FAIL content @%0t: got %h expected %h", $time, if_instruction, mem_word(next_pc)); end
            popped.push_back(if_pc);
            next_pc = next_pc + 64'd4;
            void'(mq.pop_front());
        end

        if (br_taken) begin
            m_fpc = redirect_target(br_pc, uncond_br, cond_addr19, br_addr26);
            next_pc = m_fpc;
            if (imem_rvalid) void'(m_tags.pop_front());
            m_drop = m_tags.size();
            mq.delete();
        end else begin
            if (imem_rvalid) begin
                t = m_tags.pop_front();
                if (m_drop > 0) m_drop--;
                else mq.push_back('{instr: imem_rdata, pc: t});
            end
            if (grant) begin
                m_tags.push_back(m_fpc);
                m_fpc = m_fpc + 64'd4;
            end
        end

        if (imem_rvalid) void'(pend.pop_front());
        if (imem_req && imem_gnt) pend.push_back(imem_addr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_stream();
        apply_reset();
        gnt_pct = 100; rv_pct = 100; if_ready = 1'b1;
        run(20);
        checks++; if (popped.size() != 18) begin errors++; $display("FAIL stream_count: got %0d expected 18", popped.size()); end
        for (int i = 0; i < popped.size(); i++) begin
            checks++; if (popped[i] !== 64'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, popped[i], 64'(4 * i)); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        gnt_pct = 100; rv_pct = 100; if_ready = 1'b0;
        run(10);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stopped: got %b expected 0", imem_req); end
        checks++; if (if_pc !== 64'h0) begin errors++; $display("FAIL bp_if_pc_hold: got %h expected 0", if_pc); end
        @(negedge clk);
        if_ready = 1'b1;
        run(15);
        checks++; if (popped.size() < 10) begin errors++; $display("FAIL bp_resume_count: got %0d expected at least 10", popped.size()); end
        for (int i = 0; i < popped.size(); i++) begin
            checks++; if (popped[i] !== 64'(4 * i)) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, popped[i], 64'(4 * i)); end
        end
    endtask

    task automatic test_cond_redirect();
        apply_reset();
        gnt_pct = 100; rv_pct = 0; if_ready = 1'b1;
        run(2);
        br_taken = 1'b1; uncond_br = 1'b0; br_pc = 64'h40; cond_addr19 = 19'h7FFFC;
        cycle();
        br_taken = 1'b0; rv_pct = 100;
        checks++; if (imem_addr !== 64'h30) begin errors++; $display("FAIL cond_next_req: got %h expected 30", imem_addr); end
        popped.delete();
        run(8);
        checks++; if (popped.size() == 0 || popped[0] !== 64'h30) begin errors++; $display("FAIL cond_first_pc: got %h expected 30", (popped.size() != 0) ? popped[0] : 64'hx); end
    endtask

    task automatic test_uncond_redirect();
        apply_reset();
        gnt_pct = 100; rv_pct = 0; if_ready = 1'b1;
        run(2);
        br_taken = 1'b1; uncond_br = 1'b1; br_pc = 64'h100; br_addr26 = 26'h0000010;
        rv_pct = 100;
        cycle();
        br_taken = 1'b0;
        checks++; if (imem_addr !== 64'h140) begin errors++; $display("FAIL uncond_next_req: got %h expected 140", imem_addr); end
        popped.delete();
        run(8);
        checks++; if (popped.size() == 0 || popped[0] !== 64'h140) begin errors++; $display("FAIL uncond_first_pc: got %h expected 140", (popped.size() != 0) ? popped[0] : 64'hx); end
    endtask

    task automatic test_stall();
        logic [63:0] a0;
        apply_reset();
        gnt_pct = 100; rv_pct = 100; if_ready = 1'b1;
        run(6);
        a0 = imem_addr;
        gnt_pct = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (imem_addr !== a0) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected %h", i, imem_addr, a0); end
        end
        gnt_pct = 100;
        run(10);
        for (int i = 0; i < popped.size(); i++) begin
            checks++; if (popped[i] !== 64'(4 * i)) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, popped[i], 64'(4 * i)); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        gnt_pct = 100; rv_pct = 100; if_ready = 1'b1;
        run(3);
        br_taken = 1'b1; uncond_br = 1'b0; br_pc = 64'h200; cond_addr19 = 19'h00008;
        cycle();
        uncond_br = 1'b1; br_pc = 64'h300; br_addr26 = 26'h3FFFFFF;
        cycle();
        br_taken = 1'b0;
        checks++; if (imem_addr !== 64'h2FC) begin errors++; $display("FAIL b2b_next_req: got %h expected 2fc", imem_addr); end
        popped.delete();
        run(8);
        checks++; if (popped.size() == 0 || popped[0] !== 64'h2FC) begin errors++; $display("FAIL b2b_first_pc: got %h expected 2fc", (popped.size() != 0) ? popped[0] : 64'hx); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        gnt_pct = 100; rv_pct = 100; if_ready = 1'b1;
        run(8);
        apply_reset();
        run(6);
        checks++; if (popped.size() != 4) begin errors++; $display("FAIL mrst_count: got %0d expected 4", popped.size()); end
        checks++; if (popped.size() == 0 || popped[0] !== RESET_PC) begin errors++; $display("FAIL mrst_first_pc: got %h expected %h", (popped.size() != 0) ? popped[0] : 64'hx, RESET_PC); end
    endtask

    task automatic test_random();
        apply_reset();
        gnt_pct = 70; rv_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            br_taken = ($urandom_range(99) < 8);
            if (br_taken) begin
                uncond_br   = 1'($urandom);
                cond_addr19 = 19'($urandom);
                br_addr26   = 26'($urandom);
                br_pc       = {$urandom, $urandom} & ~64'h3;
            end
            if_ready = ($urandom_range(99) < 75);
            cycle();
        end
        br_taken = 1'b0;
        checks++; if (popped.size() < 100) begin errors++; $display("FAIL random_progress: got %0d deliveries expected at least 100", popped.size()); end
    endtask

    initial begin
        reset = 1'b1;
        br_taken = 1'b0; uncond_br = 1'b0; cond_addr19 = '0; br_addr26 = '0; br_pc = '0;
        if_ready = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        gnt_pct = 100; rv_pct = 100;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_cond_redirect();
        test_uncond_redirect();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
